// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: host-side sequencer for the RC4 core's key, data-in and
// result byte ports. Holds a key register file, presents the key, streams
// upstream bytes straight into the core and buffers results in a 2-entry FIFO.
// Optional build macro: RC4_CTRL_ABORT_EN adds an `abort` input that returns
// any busy state to IDLE, flushing the FIFO and counters without a done pulse.
//
// Handshake rule for every byte port: a byte moves on a rising edge where
// valid and ready are both 1; a raised valid stays up until that happens,
// except when reset or abort clears the controller.
module rc4_stream_ctrl #(
  parameter  int KEY_LEN_MAX = 16,
  parameter  int LEN_W       = 16,
  localparam int AW          = $clog2(KEY_LEN_MAX)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RC4_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cfg_key_wr,
  input  logic [AW-1:0]    cfg_key_addr,
  input  logic [7:0]       cfg_key_data,
  input  logic [AW:0]      cfg_key_len,
  input  logic [LEN_W-1:0] cfg_msg_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             key_rvalid,
  input  logic             key_rready,
  output logic [7:0]       key_byte,
  output logic             data_rvalid,
  input  logic             data_rready,
  output logic [7:0]       data_byte,
  input  logic             data_wvalid,
  output logic             data_wready,
  input  logic [7:0]       data_res,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [7:0]       src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [7:0]       dst_data,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] KMAX = (AW + 1)'(KEY_LEN_MAX);

  state_t           state_q, state_d;
  logic [7:0]       key_q [KEY_LEN_MAX];
  logic [7:0]       key_d [KEY_LEN_MAX];
  logic [AW:0]      klen_q, klen_d;
  logic [AW-1:0]    kidx_q, kidx_d;
  logic [LEN_W-1:0] mlen_q, mlen_d;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [7:0]       fifo_q [2];
  logic [7:0]       fifo_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic [AW:0]      klen_norm;
  logic             abort_w;
  logic             in_act;
  logic             push;
  logic             pop;
  logic             wr_ptr;

`ifdef RC4_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Key length normalisation: zero means one byte, oversize clamps to depth.
  always_comb begin
    klen_norm = cfg_key_len;
    if (cfg_key_len == '0) klen_norm = (AW + 1)'(1);
    else if (cfg_key_len > KMAX) klen_norm = KMAX;
  end

  // Next-state, datapath and port outputs for the message sequencer.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    klen_d      = klen_q;
    kidx_d      = kidx_q;
    mlen_d      = mlen_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    key_rvalid  = 1'b0;
    key_byte    = 8'h00;
    data_rvalid = 1'b0;
    src_ready   = 1'b0;
    data_byte   = 8'h00;
    data_wready = 1'b0;
    done        = 1'b0;
    in_act      = 1'b0;
    push        = 1'b0;
    busy        = (state_q != S_IDLE);
    state_dbg   = state_q;
    dst_valid   = (cnt_q != 2'd0);
    dst_data    = fifo_q[rd_ptr_q];
    pop         = dst_valid & dst_ready;
    // write slot sits one past the head when a single byte is buffered
    wr_ptr      = rd_ptr_q ^ cnt_q[0];

    case (state_q)
      S_IDLE: begin
        if (cfg_key_wr) key_d[cfg_key_addr] = cfg_key_data;
        if (start) begin
          klen_d    = klen_norm;
          mlen_d    = cfg_msg_len;
          kidx_d    = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = S_KEY;
        end
      end
      S_KEY: begin
        key_rvalid = 1'b1;
        key_byte   = key_q[kidx_q];
        if (key_rready) begin
          kidx_d = kidx_q + AW'(1);
          if ({1'b0, kidx_q} == klen_q - (AW + 1)'(1)) state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_act      = (in_cnt_q < mlen_q);
        data_rvalid = in_act & src_valid;
        src_ready   = in_act & data_rready;
        data_byte   = in_act ? src_data : 8'h00;
        if (in_act && src_valid && data_rready) in_cnt_d = in_cnt_q + LEN_W'(1);
        data_wready = (cnt_q != 2'd2) && (out_cnt_q < mlen_q);
        push        = data_wready & data_wvalid;
        if (push) begin
          fifo_d[wr_ptr] = data_res;
          out_cnt_d      = out_cnt_q + LEN_W'(1);
        end
      end
      S_DONE: begin
        done    = ~abort_w;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;

    // finish once every result is counted in and the last one has left
    if (state_q == S_DATA && out_cnt_d == mlen_q && cnt_d == 2'd0) state_d = S_DONE;

    if (abort_w && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cnt_d     = 2'd0;
      rd_ptr_d  = 1'b0;
      kidx_d    = '0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      klen_q    <= '0;
      kidx_q    <= '0;
      mlen_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      for (int i = 0; i < KEY_LEN_MAX; i++) key_q[i] <= 8'h00;
      for (int i = 0; i < 2; i++) fifo_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      klen_q    <= klen_d;
      kidx_q    <= kidx_d;
      mlen_q    <= mlen_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < KEY_LEN_MAX; i++) key_q[i] <= key_d[i];
      for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Bench for rc4_stream_ctrl: plays both the upstream source and an RC4 core
// that answers each data byte with byte ^ 0xFF one cycle later. Expected
// downstream bytes are queued as source bytes are accepted.
module tb_rc4_stream_ctrl;
  localparam int KL = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          cfg_key_wr;
  logic [3:0]    cfg_key_addr;
  logic [7:0]    cfg_key_data;
  logic [4:0]    cfg_key_len;
  logic [LW-1:0] cfg_msg_len;
  logic          start;
  logic          busy, done;
  logic          key_rvalid, key_rready;
  logic [7:0]    key_byte;
  logic          data_rvalid, data_rready;
  logic [7:0]    data_byte;
  logic          data_wvalid, data_wready;
  logic [7:0]    data_res;
  logic          src_valid, src_ready;
  logic [7:0]    src_data;
  logic          dst_valid, dst_ready;
  logic [7:0]    dst_data;
  logic [1:0]    state_dbg;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] core_q[$];
  logic [7:0] key_model[KL];

  rc4_stream_ctrl #(.KEY_LEN_MAX(KL), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
`ifdef RC4_CTRL_ABORT_EN
    .abort(abort),
`endif
    .cfg_key_wr(cfg_key_wr), .cfg_key_addr(cfg_key_addr), .cfg_key_data(cfg_key_data),
    .cfg_key_len(cfg_key_len), .cfg_msg_len(cfg_msg_len), .start(start),
    .busy(busy), .done(done),
    .key_rvalid(key_rvalid), .key_rready(key_rready), .key_byte(key_byte),
    .data_rvalid(data_rvalid), .data_rready(data_rready), .data_byte(data_byte),
    .data_wvalid(data_wvalid), .data_wready(data_wready), .data_res(data_res),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    abort = 1'b0; cfg_key_wr = 1'b0; start = 1'b0;
    key_rready = 1'b0; data_rready = 1'b0; data_wvalid = 1'b0; data_res = 8'h00;
    src_valid = 1'b0; src_data = 8'h00; dst_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {busy, done, key_rvalid, data_rvalid, src_ready, data_wready, dst_valid,
              key_byte, dst_data}, 32'h0);
  endtask

  task automatic write_key(input int addr, input logic [7:0] data);
    cfg_key_wr = 1'b1; cfg_key_addr = 4'(addr); cfg_key_data = data;
    tick();
    cfg_key_wr = 1'b0;
    key_model[addr] = data;
  endtask

  // start at cycle 0, then expect n key bytes on cycles 1..n and DATA at n+1
  task automatic run_key(input int klen_cfg, input int mlen, input int n);
    cfg_key_len = 5'(klen_cfg); cfg_msg_len = LW'(mlen);
    start = 1'b1; key_rready = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      chk("key_rvalid", key_rvalid, 1);
      chk($sformatf("key_byte[%0d]", i), key_byte, key_model[i]);
      tick();
      #1;
    end
    chk("key_rvalid_after", key_rvalid, 0);
    chk("state_data", state_dbg, 2'd2);
    key_rready = 1'b0;
  endtask

  // kill_kind: 0 = reset, 1 = abort
  task automatic data_phase(input int mlen, input int gaps, input int bp_start, input int bp_len,
                            input int kill_at, input int kill_kind, input int poke,
                            input logic [7:0] base);
    int src_idx = 0;
    int c = 0;
    int last_pop = -10;
    bit src_v = 1'b0;
    bit fin = 1'b0;
    bit killed = 1'b0;
    logic [7:0] sd = 8'h00;
    while (!fin && c < 300) begin
      if (!src_v && src_idx < mlen) begin
        src_v = gaps != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
        sd = 8'(base + 8'(src_idx));
      end
      src_valid   = src_v;
      src_data    = sd;
      data_rready = 1'b1;
      data_wvalid = (core_q.size() != 0);
      data_res    = data_wvalid ? core_q[0] : 8'h00;
      dst_ready   = !(c >= bp_start && c < bp_start + bp_len);
      if (poke != 0 && c == 1) begin
        start = 1'b1; cfg_key_wr = 1'b1; cfg_key_addr = 4'd0; cfg_key_data = 8'hEE;
      end else begin
        start = 1'b0; cfg_key_wr = 1'b0;
      end
      #1;
      if (done) begin
        chk("done_timing", c, (mlen == 0) ? 1 : last_pop + 1);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("src_count", src_idx, mlen);
        fin = 1'b1;
      end
      if (mlen == 0 && c == 0) chk("no_data_hs", {data_rvalid, src_ready, data_wready}, 0);
      if (bp_len > 0 && c == bp_start + bp_len - 1) begin
        chk("bp_wready_low", data_wready, 0);
        chk("bp_dst_valid", dst_valid, 1);
      end
      if (data_rvalid && data_rready) core_q.push_back(data_byte ^ 8'hFF);
      if (src_valid && src_ready) begin
        exp_q.push_back(src_data ^ 8'hFF);
        src_idx++;
        src_v = 1'b0;
      end
      if (data_wvalid && data_wready) void'(core_q.pop_front());
      if (dst_valid && dst_ready) begin
        if (exp_q.size() == 0) chk("dst_unexpected", exp_q.size(), 1);
        else chk("dst_data", dst_data, exp_q.pop_front());
        last_pop = c;
      end
      if (kill_at > 0 && src_idx == kill_at && !fin) begin
        tick();
        idle_inputs();
        if (kill_kind == 0) rst = 1'b1;
        else abort = 1'b1;
        tick();
        #1;
        if (kill_kind == 0) chk_reset_outputs("reset_outputs");
        else chk("abort_outputs", {busy, done, key_rvalid, data_rvalid, src_ready,
                                   data_wready, dst_valid}, 0);
        rst = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          #1;
          chk("no_done_after_kill", {busy, done}, 0);
        end
        exp_q.delete();
        core_q.delete();
        if (kill_kind == 0) for (int i = 0; i < KL; i++) key_model[i] = 8'h00;
        killed = 1'b1;
        fin = 1'b1;
      end else begin
        tick();
        c++;
      end
    end
    if (!fin) chk("timeout", fin, 1);
    else if (!killed) begin
      idle_inputs();
      #1;
      chk("busy_cleared", busy, 0);
      chk("done_single", done, 0);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cfg_key_addr = 4'd0; cfg_key_data = 8'h00; cfg_key_len = 5'd0; cfg_msg_len = '0;
    for (int i = 0; i < KL; i++) key_model[i] = 8'h00;
    tick();
    tick();
    #1;
    chk_reset_outputs("reset_state");
    rst = 1'b0;
    tick();
    #1;
    chk("idle_after_reset", {busy, state_dbg}, 0);

    // key load and basic stream
    for (int i = 0; i < 5; i++) write_key(i, 8'(i + 1));
    run_key(5, 4, 5);
    data_phase(4, 0, 0, 0, 0, 0, 0, 8'hA0);

    // downstream backpressure, plus start/key write attempted while busy
    run_key(5, 8, 5);
    data_phase(8, 0, 3, 10, 0, 0, 1, 8'h30);

    // key length 0 sends one byte; empty message; key[0] must still be 0x01
    run_key(0, 0, 1);
    data_phase(0, 0, 0, 0, 0, 0, 0, 8'h00);

    // oversize key length clamps to full depth; random source gaps
    for (int i = 5; i < KL; i++) write_key(i, 8'($urandom_range(0, 255)));
    run_key(20, 3, 16);
    data_phase(3, 1, 0, 0, 0, 0, 0, 8'hC0);

    // reset in DATA after 2 of 6 bytes, then a complete message
    run_key(3, 6, 3);
    data_phase(6, 0, 0, 0, 2, 0, 0, 8'h10);
    for (int i = 0; i < 3; i++) write_key(i, 8'h90 + 8'(i));
    run_key(3, 6, 3);
    data_phase(6, 1, 2, 4, 0, 0, 0, 8'h60);

`ifdef RC4_CTRL_ABORT_EN
    run_key(3, 6, 3);
    data_phase(6, 0, 0, 0, 2, 1, 0, 8'h20);
    run_key(3, 6, 3);
    data_phase(6, 0, 0, 0, 0, 0, 0, 8'h70);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
